// File: rtl/boxcar_decimator_if.sv
// boxcar_decimator_if: sample-in / average-out bundle between a boxcar decimator and its neighbours.
interface boxcar_decimator_if #(
   parameter int DATA_WIDTH = 8,
   parameter int MAX_LOG2_N = 6
);
   localparam int KW = $clog2(MAX_LOG2_N + 1);
   logic [KW-1:0]         log2_n;
   logic                  clr;
   logic                  din_valid;
   logic [DATA_WIDTH-1:0] din;
   logic [DATA_WIDTH-1:0] dout;
   logic                  dout_valid;
   modport master (output log2_n, clr, din_valid, din, input dout, dout_valid);
   modport slave (input log2_n, clr, din_valid, din, output dout, dout_valid);
endinterface

// File: rtl/boxcar_decimator.sv
// boxcar_decimator: integrate-and-dump averager, sums 2^k valid samples and emits one rounded,
// saturated average with a single-cycle strobe.
module boxcar_decimator #(
   parameter int DATA_WIDTH = 8,
   parameter int MAX_LOG2_N = 6
) (
   input  logic               clk,
   input  logic               resetn,
   boxcar_decimator_if.slave  bus
);
   localparam int KW = $clog2(MAX_LOG2_N + 1);
   localparam int AW = DATA_WIDTH + MAX_LOG2_N;
   localparam logic signed [AW:0]         OUT_MAX = (AW+1)'(2 ** (DATA_WIDTH - 1) - 1);
   localparam logic signed [AW:0]         OUT_MIN = ~OUT_MAX;
   localparam logic [AW:0]                ONE_W   = (AW+1)'(1);
   localparam logic [MAX_LOG2_N:0]        ONE_M   = (MAX_LOG2_N+1)'(1);
   localparam logic [MAX_LOG2_N-1:0]      ONE_C   = MAX_LOG2_N'(1);
   localparam logic [KW-1:0]              K_MAX   = KW'(MAX_LOG2_N);
   typedef enum logic {IDLE, ACCUM} state_t;
   state_t                  state_q, state_d;
   logic signed [AW-1:0]    acc_q, acc_d;
   logic [MAX_LOG2_N-1:0]   cnt_q, cnt_d;
   logic [KW-1:0]           k_q, k_d;
   logic [DATA_WIDTH-1:0]   dout_q, dout_d;
   logic                    dout_valid_q, dout_valid_d;
   logic [KW-1:0]           k_in, k_eff;
   logic                    start, last, dump;
   logic signed [AW-1:0]    acc_base;
   logic [MAX_LOG2_N-1:0]   cnt_base;
   logic [MAX_LOG2_N:0]     mask;
   logic signed [AW:0]      sum, rnd, tot, avg;
   logic [DATA_WIDTH-1:0]   sat;
   // A new block begins from IDLE or whenever clr discards the partial sum.
   always_comb begin
      k_in     = (bus.log2_n > K_MAX) ? K_MAX : bus.log2_n;
      start    = (state_q == IDLE) || bus.clr;
      k_eff    = start ? k_in : k_q;
      acc_base = start ? '0 : acc_q;
      cnt_base = start ? '0 : cnt_q;
      mask     = (ONE_M << k_eff) - ONE_M;
      last     = {1'b0, cnt_base} == mask;
      dump     = bus.din_valid && last;
      sum      = {acc_base[AW-1], acc_base} + {{(AW+1-DATA_WIDTH){bus.din[DATA_WIDTH-1]}}, bus.din};
      rnd      = (ONE_W << k_eff) >> 1;
      tot      = sum + rnd;
      avg      = tot >>> k_eff;
      sat      = (avg > OUT_MAX) ? OUT_MAX[DATA_WIDTH-1:0] :
                 (avg < OUT_MIN) ? OUT_MIN[DATA_WIDTH-1:0] : avg[DATA_WIDTH-1:0];
   end
   always_comb begin
      acc_d        = dump ? '0 : bus.din_valid ? sum[AW-1:0] : bus.clr ? '0 : acc_q;
      cnt_d        = dump ? '0 : bus.din_valid ? cnt_base + ONE_C : bus.clr ? '0 : cnt_q;
      state_d      = dump ? IDLE : bus.din_valid ? ACCUM : bus.clr ? IDLE : state_q;
      k_d          = bus.din_valid ? k_eff : k_q;
      dout_d       = dump ? sat : dout_q;
      dout_valid_d = dump;
   end
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= IDLE;
         acc_q        <= '0;
         cnt_q        <= '0;
         k_q          <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
         k_q          <= k_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
      end
   end
   assign bus.dout       = dout_q;
   assign bus.dout_valid = dout_valid_q;
endmodule

// File: tb/tb_boxcar_decimator.sv
// tb_boxcar_decimator: scenario tasks plus randomized traffic, checked against a block-average
// reference model built from integer arithmetic.
module tb_boxcar_decimator;
   localparam int DW = 8;
   localparam int ML = 6;
   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;
   boxcar_decimator_if #(.DATA_WIDTH(DW), .MAX_LOG2_N(ML)) bus ();
   boxcar_decimator #(.DATA_WIDTH(DW), .MAX_LOG2_N(ML)) dut (.clk(clk), .resetn(resetn), .bus(bus));
   int n_chk = 0;
   int n_fail = 0;
   int m_sum = 0, m_cnt = 0, m_k = 0;
   bit exp_v = 1'b0;
   int exp_d = 0;

   function automatic int floor_div(input int num, input int den);
      int q = num / den;
      if ((num % den) != 0 && num < 0) q -= 1;
      return q;
   endfunction

   // Drive one clock of input and advance the reference model to what the outputs must show.
   task automatic step(input bit v, input int d, input bit c, input int l2n);
      bus.din_valid = v;
      bus.din       = DW'(d);
      bus.clr       = c;
      bus.log2_n    = 3'(l2n);
      @(posedge clk);
      if (c) begin
         m_sum = 0;
         m_cnt = 0;
      end
      exp_v = 1'b0;
      if (v) begin
         if (m_cnt == 0) m_k = (l2n > ML) ? ML : l2n;
         m_sum += d;
         m_cnt++;
         if (m_cnt == (1 << m_k)) begin
            exp_v = 1'b1;
            exp_d = floor_div(m_sum + (1 << m_k) / 2, 1 << m_k);
            if (exp_d > 127) exp_d = 127;
            if (exp_d < -128) exp_d = -128;
            m_sum = 0;
            m_cnt = 0;
         end
      end
      #1;
   endtask

   task automatic model_reset();
      m_sum = 0;
      m_cnt = 0;
      m_k   = 0;
      exp_v = 1'b0;
      exp_d = 0;
   endtask

   task automatic test_reset();
      bus.din_valid = 1'b0;
      bus.din       = '0;
      bus.clr       = 1'b0;
      bus.log2_n    = '0;
      resetn        = 1'b0;
      model_reset();
      #12;
      n_chk++;
      if (bus.dout_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_valid: got %0b, want 0", bus.dout_valid);
      end
      n_chk++;
      if (bus.dout !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_dout: got %0d, want 0", $signed(bus.dout));
      end
      @(negedge clk);
      resetn = 1'b1;
   endtask

   task automatic test_nominal();
      int seq[] = '{1, -1, 10, -2, -5, -6, 0, -1};
      int strobes = 0;
      foreach (seq[i]) begin
         step(1'b1, seq[i], 1'b0, 2);
         strobes += int'(bus.dout_valid);
         n_chk++;
         if (bus.dout_valid !== exp_v || $signed(bus.dout) !== exp_d) begin
            n_fail++;
            $display("FAIL nominal[%0d]: got v=%0b d=%0d, want v=%0b d=%0d", i, bus.dout_valid, $signed(bus.dout), exp_v, exp_d);
         end
      end
      n_chk++;
      if (strobes !== 2) begin
         n_fail++;
         $display("FAIL nominal_strobes: got %0d, want 2", strobes);
      end
   endtask

   task automatic test_passthrough();
      int seq[] = '{10, -2, -5};
      foreach (seq[i]) begin
         step(1'b1, seq[i], 1'b0, 0);
         n_chk++;
         if (bus.dout_valid !== 1'b1 || $signed(bus.dout) !== seq[i]) begin
            n_fail++;
            $display("FAIL passthrough[%0d]: got v=%0b d=%0d, want v=1 d=%0d", i, bus.dout_valid, $signed(bus.dout), seq[i]);
         end
      end
   endtask

   task automatic test_full_scale();
      int strobes = 0;
      for (int b = 0; b < 2; b++) begin
         for (int i = 0; i < 64; i++) begin
            step(1'b1, (b == 0) ? 127 : -128, 1'b0, 6);
            strobes += int'(bus.dout_valid);
            n_chk++;
            if (bus.dout_valid !== exp_v || $signed(bus.dout) !== exp_d) begin
               n_fail++;
               $display("FAIL full_scale[%0d][%0d]: got v=%0b d=%0d, want v=%0b d=%0d", b, i, bus.dout_valid, $signed(bus.dout), exp_v, exp_d);
            end
         end
      end
      n_chk++;
      if (strobes !== 2 || $signed(bus.dout) !== -128) begin
         n_fail++;
         $display("FAIL full_scale_end: got strobes=%0d d=%0d, want 2/-128", strobes, $signed(bus.dout));
      end
   endtask

   task automatic test_gaps_exponent();
      int v[]  = '{1, 0, 0, 0, 0, 1, 1, 0, 1};
      int d[]  = '{3, 9, 9, 9, 9, 4, 6, 50, 2};
      int l2[] = '{1, 1, 1, 1, 1, 1, 1, 2, 2};
      foreach (v[i]) begin
         step(v[i] != 0, d[i], 1'b0, l2[i]);
         n_chk++;
         if (bus.dout_valid !== exp_v || $signed(bus.dout) !== exp_d) begin
            n_fail++;
            $display("FAIL gaps[%0d]: got v=%0b d=%0d, want v=%0b d=%0d", i, bus.dout_valid, $signed(bus.dout), exp_v, exp_d);
         end
      end
      n_chk++;
      if ($signed(bus.dout) !== 4) begin
         n_fail++;
         $display("FAIL gaps_kchange: got %0d, want 4", $signed(bus.dout));
      end
   endtask

   task automatic test_clr();
      int v[] = '{1, 1, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1};
      int d[] = '{5, 5, 8, 8, 8, 8, 7, 0, -6, -6, -6, -6};
      int c[] = '{0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0};
      foreach (v[i]) begin
         step(v[i] != 0, d[i], c[i] != 0, 2);
         n_chk++;
         if (bus.dout_valid !== exp_v || $signed(bus.dout) !== exp_d) begin
            n_fail++;
            $display("FAIL clr[%0d]: got v=%0b d=%0d, want v=%0b d=%0d", i, bus.dout_valid, $signed(bus.dout), exp_v, exp_d);
         end
      end
   endtask

   task automatic test_reset_mid();
      step(1'b1, 100, 1'b0, 2);
      step(1'b1, 100, 1'b0, 2);
      bus.din_valid = 1'b0;
      #2 resetn = 1'b0;
      #1;
      model_reset();
      n_chk++;
      if (bus.dout_valid !== 1'b0 || bus.dout !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_mid: got v=%0b d=%0d, want v=0 d=0", bus.dout_valid, $signed(bus.dout));
      end
      @(negedge clk);
      resetn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step(1'b1, -4, 1'b0, 2);
         n_chk++;
         if (bus.dout_valid !== exp_v || $signed(bus.dout) !== exp_d) begin
            n_fail++;
            $display("FAIL reset_mid_after[%0d]: got v=%0b d=%0d, want v=%0b d=%0d", i, bus.dout_valid, $signed(bus.dout), exp_v, exp_d);
         end
      end
   endtask

   task automatic test_random();
      int l2n = 3;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 99) < 3) l2n = int'($urandom_range(0, 7));
         step($urandom_range(0, 99) < 75, int'($urandom_range(0, 255)) - 128, $urandom_range(0, 199) == 0, l2n);
         n_chk++;
         if (bus.dout_valid !== exp_v || $signed(bus.dout) !== exp_d) begin
            n_fail++;
            $display("FAIL random[%0d]: got v=%0b d=%0d, want v=%0b d=%0d", i, bus.dout_valid, $signed(bus.dout), exp_v, exp_d);
         end
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_passthrough();
      test_full_scale();
      test_gaps_exponent();
      test_clr();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/boxcar_decimator.md
# boxcar_decimator

Integrate-and-dump averaging decimator: accumulates N = 2^log2_n consecutive valid signed samples, then emits one rounded average and a one-cycle valid strobe. It is the rate-reducing counterpart of the full-rate boxcar_filter. It sits after a boxcar/ADC stage, where a low-rate averaged stream is read out to a FIFO or a register bank.

## Interface
- DATA_WIDTH, 8, sample width of din/dout (two's complement)
- MAX_LOG2_N, 6, largest supported decimation exponent (N up to 64)
- clk  in  1  sole clock, all logic rising-edge
- resetn  in  1  asynchronous, active-low reset
- log2_n  in  $clog2(MAX_LOG2_N+1)  decimation exponent; values > MAX_LOG2_N treated as MAX_LOG2_N
- clr  in  1  synchronous restart of the current block
- din_valid  in  1  din is a sample this cycle
- din  in  DATA_WIDTH  signed input sample
- dout  out  DATA_WIDTH  signed averaged output, registered
- dout_valid  out  1  one-cycle strobe, dout updated this cycle

## Operation
- Accumulator acc: signed, DATA_WIDTH+MAX_LOG2_N bits, sign-extended adds; never overflows.
- Sample counter cnt: MAX_LOG2_N bits; counts accepted samples in current block.
- Block exponent k: latched from (clamped) log2_n when the first sample of a block is accepted. log2_n changes mid-block have no effect until the next block.
- States: IDLE (cnt=0, no partial sum) and ACCUM (partial sum held). IDLE→ACCUM on accepted sample when k>0; ACCUM→IDLE on accepting the N-th sample or on clr.
- Accept: din_valid=1 and resetn=1. Cycles with din_valid=0 leave acc, cnt, k unchanged; gaps of any length are allowed.
- Dump on the N-th accepted sample:
  - sum = acc + din.
  - dout = (sum + 2^(k-1)) >>> k, i.e. round half toward +inf. For k=0, dout = din.
  - The result is clamped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. The clamp is unreachable for legal inputs but is implemented.
  - acc and cnt return to 0.
- clr=1 discards any partial sum.
  - If din_valid=1 in the same cycle, that sample is the first of a new block, with k latched from the current log2_n.
  - clr never produces an output.
- k=0: every accepted sample is dumped immediately (pass-through, 1-cycle latency).

## Timing
- Reset values: dout=0, dout_valid=0, acc=0, cnt=0, k=0, state IDLE. Asserting resetn low mid-block discards the partial sum; the first accepted sample after release starts a fresh block.
- Latency: dout/dout_valid are registered and appear on the rising edge that samples the N-th accepted din. They are visible the cycle after din is presented.
- dout_valid is high for exactly one cycle per block. dout holds its value until the next dump.
- Maximum throughput: one sample per clock. Back-to-back blocks have no dead cycle; the sample after a dump is accepted on the very next clock.
- clr and the N-th sample in the same cycle: clr wins. No output is produced, and that sample starts a new block.
- No backpressure: the downstream consumer must accept dout whenever dout_valid=1.

## Test plan
- Nominal, log2_n=2, din_valid=1 continuously, din = 1,-1,10,-2,-5,-6,0,-1 → dout_valid strobes after samples 4 and 8 with dout=2 (8+2>>2), then dout=-3 (-12+2>>>2). No other strobes.
- Pass-through, log2_n=0, din = 10,-2,-5 → dout_valid high 3 consecutive cycles, dout = 10,-2,-5, each one cycle after its input.
- Full scale, log2_n=6, 64 samples of 127 → dout=127; then 64 samples of -128 → dout=-128; exactly one strobe per block.
- Gaps and mid-block exponent change, log2_n=1:
  - din 3 (valid), 4 cycles valid=0, din 4 (valid) → dout=4 ((7+1)>>1).
  - Changing log2_n to 2 after the first sample of a block does not alter that block.
- clr:
  - log2_n=2, samples 5,5 then clr with din_valid=1, din=8, then 8,8,8 → single strobe, dout=8; the 5s are discarded.
  - clr with din_valid=0 → next block starts empty.
- Reset mid-block: log2_n=2, samples 100,100 then resetn pulse low → dout=0, dout_valid=0 immediately. Afterwards 4 samples of -4 → dout=-4.
